// File: rtl/lakespec_pkg.sv
// lakespec_pkg: shared widths, config field offsets, per-port config struct
// and the helper that unpacks one 275-bit port slice into that struct.
package lakespec_pkg;

   localparam int DATA_WIDTH     = 16;
   localparam int MEM_DEPTH      = 512;
   localparam int ADDR_WIDTH     = 9;
   localparam int MAX_DIM        = 6;
   localparam int CNT_WIDTH      = 16;
   localparam int DIM_WIDTH      = 3;
   localparam int PORT_CFG_WIDTH = 275;
   localparam int CONFIG_WIDTH   = 2 * PORT_CFG_WIDTH;

   // Field offsets inside one port slice, LSB first.
   localparam int OFS_ENABLE       = 0;
   localparam int OFS_DIM          = 1;
   localparam int OFS_EXTENT       = 4;
   localparam int OFS_ADDR_OFFSET  = 100;
   localparam int OFS_ADDR_STRIDE  = 109;
   localparam int OFS_SCHED_OFFSET = 163;
   localparam int OFS_SCHED_STRIDE = 179;

   typedef struct packed {
      logic                                enable;
      logic [DIM_WIDTH-1:0]                dim;
      logic [MAX_DIM-1:0][CNT_WIDTH-1:0]   extent_m1;
      logic [ADDR_WIDTH-1:0]               addr_offset;
      logic [MAX_DIM-1:0][ADDR_WIDTH-1:0]  addr_stride;
      logic [CNT_WIDTH-1:0]                sched_offset;
      logic [MAX_DIM-1:0][CNT_WIDTH-1:0]   sched_stride;
   } port_cfg_t;

   function automatic port_cfg_t unpack_port_cfg(input logic [PORT_CFG_WIDTH-1:0] raw);
      port_cfg_t c;
      c.enable       = raw[OFS_ENABLE];
      c.dim          = raw[OFS_DIM +: DIM_WIDTH];
      c.addr_offset  = raw[OFS_ADDR_OFFSET +: ADDR_WIDTH];
      c.sched_offset = raw[OFS_SCHED_OFFSET +: CNT_WIDTH];
      for (int i = 0; i < MAX_DIM; i++) begin
         c.extent_m1[i]    = raw[OFS_EXTENT + CNT_WIDTH * i +: CNT_WIDTH];
         c.addr_stride[i]  = raw[OFS_ADDR_STRIDE + ADDR_WIDTH * i +: ADDR_WIDTH];
         c.sched_stride[i] = raw[OFS_SCHED_STRIDE + CNT_WIDTH * i +: CNT_WIDTH];
      end
      return c;
   endfunction

endpackage

// File: rtl/lakespec_port_ctrl.sv
// lakespec_port_ctrl: loop-nest iterator plus affine address and schedule
// generators for one port. fire is asserted in the cycle the global count
// matches the current schedule value; addr is valid alongside it.
module lakespec_port_ctrl
   import lakespec_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      flush,
   input  logic [PORT_CFG_WIDTH-1:0] port_cfg,
   input  logic [CNT_WIDTH-1:0]      cycle_count,
   output logic                      fire,
   output logic [ADDR_WIDTH-1:0]     addr
);

   port_cfg_t                          cfg_s;
   logic [MAX_DIM-1:0][CNT_WIDTH-1:0]  iter_r;
   logic [MAX_DIM-1:0][CNT_WIDTH-1:0]  iter_next_s;
   logic                               wrap_all_s;
   logic                               done_r;
   logic                               active_s;
   logic                               fire_s;
   logic [ADDR_WIDTH-1:0]              addr_s;
   logic [CNT_WIDTH-1:0]               sched_s;

   assign cfg_s = unpack_port_cfg(port_cfg);

   // Affine address (mod 512) and schedule (mod 2^16); unused loops stay at zero.
   always_comb begin
      addr_s  = cfg_s.addr_offset;
      sched_s = cfg_s.sched_offset;
      for (int i = 0; i < MAX_DIM; i++) begin
         addr_s  = addr_s + cfg_s.addr_stride[i] * iter_r[i][ADDR_WIDTH-1:0];
         sched_s = sched_s + cfg_s.sched_stride[i] * iter_r[i];
      end
   end

   // Odometer step: loop 0 innermost, carry ripples outward through active loops.
   always_comb begin
      logic carry;
      carry       = 1'b1;
      iter_next_s = iter_r;
      for (int i = 0; i < MAX_DIM; i++) begin
         if (carry && (i < int'(cfg_s.dim))) begin
            if (iter_r[i] == cfg_s.extent_m1[i]) begin
               iter_next_s[i] = {CNT_WIDTH{1'b0}};
            end else begin
               iter_next_s[i] = iter_r[i] + 16'd1;
               carry          = 1'b0;
            end
         end else begin
            iter_next_s[i] = iter_r[i];
         end
      end
      wrap_all_s = carry;
   end

   // rst_n is active-high here: a port may only fire while it is low.
   assign active_s = cfg_s.enable && (cfg_s.dim != 3'd0) && !done_r;
   assign fire_s   = !rst_n && !flush && active_s && (cycle_count == sched_s);

   // Iterator and done state: reset over flush over fire.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         iter_r <= '0;
         done_r <= 1'b0;
      end else if (flush) begin
         iter_r <= '0;
         done_r <= 1'b0;
      end else if (fire_s) begin
         iter_r <= iter_next_s;
         done_r <= wrap_all_s;
      end else begin
         iter_r <= iter_r;
         done_r <= done_r;
      end
   end

   assign fire = fire_s;
   assign addr = addr_s;

endmodule

// File: rtl/lakespec.sv
// lakespec: single-write / single-read statically scheduled storage.
// Holds the saturating cycle counter, the 512x16 array and the port_1 register.
module lakespec
   import lakespec_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    flush,
   input  logic [CONFIG_WIDTH-1:0] config_memory_size_550,
   input  logic [DATA_WIDTH-1:0]   port_0,
   output logic [DATA_WIDTH-1:0]   port_1
);

   logic [CNT_WIDTH-1:0]  cycle_r;
   logic                  wr_fire_s;
   logic                  rd_fire_s;
   logic [ADDR_WIDTH-1:0] wr_addr_s;
   logic [ADDR_WIDTH-1:0] rd_addr_s;
   logic [DATA_WIDTH-1:0] mem_r [0:MEM_DEPTH-1];
   logic [DATA_WIDTH-1:0] port_1_r;

   // Cycle counter: cleared by reset or flush, otherwise counts up and sticks at all-ones.
   always_ff @(posedge clk) begin
      if (rst_n || flush) begin
         cycle_r <= 16'd0;
      end else if (cycle_r != 16'hFFFF) begin
         cycle_r <= cycle_r + 16'd1;
      end else begin
         cycle_r <= cycle_r;
      end
   end

   lakespec_port_ctrl u_wr_ctrl (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush       (flush),
      .port_cfg    (config_memory_size_550[PORT_CFG_WIDTH-1:0]),
      .cycle_count (cycle_r),
      .fire        (wr_fire_s),
      .addr        (wr_addr_s)
   );

   lakespec_port_ctrl u_rd_ctrl (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush       (flush),
      .port_cfg    (config_memory_size_550[CONFIG_WIDTH-1:PORT_CFG_WIDTH]),
      .cycle_count (cycle_r),
      .fire        (rd_fire_s),
      .addr        (rd_addr_s)
   );

   // Storage write; contents survive reset and flush.
   always_ff @(posedge clk) begin
      if (wr_fire_s) begin
         mem_r[wr_addr_s] <= port_0;
      end
   end

   // Registered read; same-address collision returns the pre-write word.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         port_1_r <= 16'd0;
      end else if (rd_fire_s) begin
         port_1_r <= mem_r[rd_addr_s];
      end else begin
         port_1_r <= port_1_r;
      end
   end

   assign port_1 = port_1_r;

endmodule

// File: tb/tb_lakespec.sv
// tb_lakespec: directed scenarios against a flat-iteration-list model of lakespec.
module tb_lakespec;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         flush;
   logic [549:0] cfg;
   logic [15:0]  port_0;
   logic [15:0]  port_1;

   always #5 clk = ~clk;

   lakespec dut (
      .clk                    (clk),
      .rst_n                  (rst_n),
      .flush                  (flush),
      .config_memory_size_550 (cfg),
      .port_0                 (port_0),
      .port_1                 (port_1)
   );

   int          n_vec = 0;
   int          n_err = 0;
   logic [15:0] pat;
   longint      tcyc;
   logic [15:0] m_cnt;
   logic [15:0] m_p1;
   bit          m_p1_known;
   int          m_kw, m_kr;
   logic [15:0] m_mem  [512];
   bit          m_mval [512];
   int          w_sched[$], w_addr[$], r_sched[$], r_addr[$];

   // Build one port config slice from field values (offsets from the field layout).
   function automatic logic [274:0] pc(input bit en, input int dim, e0, e1, ao, as0, as1,
                                       so, ss0, ss1);
      logic [274:0] c;
      c = '0;
      c[0]        = en;
      c[3:1]      = 3'(dim);
      c[4 +: 16]  = 16'(e0);
      c[20 +: 16] = 16'(e1);
      c[100 +: 9] = 9'(ao);
      c[109 +: 9] = 9'(as0);
      c[118 +: 9] = 9'(as1);
      c[163 +: 16] = 16'(so);
      c[179 +: 16] = 16'(ss0);
      c[195 +: 16] = 16'(ss1);
      return c;
   endfunction

   // Flatten the loop nest into an ordered list of (schedule, address) pairs.
   task automatic enumerate(input logic [274:0] c, input bit rd);
      int     dim;
      longint total, rem, d, a, s;
      longint ext [6];
      if (rd) begin
         r_sched.delete(); r_addr.delete();
      end else begin
         w_sched.delete(); w_addr.delete();
      end
      dim = int'(c[3:1]);
      if (dim > 6) dim = 6;
      if (c[0] == 1'b1 && dim != 0) begin
         total = 1;
         for (int i = 0; i < dim; i++) begin
            ext[i] = longint'(c[4 + 16 * i +: 16]) + 1;
            total  = total * ext[i];
         end
         for (longint idx = 0; idx < total; idx++) begin
            rem = idx;
            a   = longint'(c[100 +: 9]);
            s   = longint'(c[163 +: 16]);
            for (int i = 0; i < dim; i++) begin
               d   = rem % ext[i];
               rem = rem / ext[i];
               a   = a + longint'(c[109 + 9 * i +: 9]) * d;
               s   = s + longint'(c[179 + 16 * i +: 16]) * d;
            end
            if (rd) begin
               r_addr.push_back(int'(a % 512));
               r_sched.push_back(int'(s % 65536));
            end else begin
               w_addr.push_back(int'(a % 512));
               w_sched.push_back(int'(s % 65536));
            end
         end
      end
   endtask

   // One clock: advance the model, drive next port_0, compare port_1 on the falling edge.
   task automatic step();
      logic [15:0] nc, np1;
      bit          nk;
      int          nkw, nkr;
      nc = m_cnt; np1 = m_p1; nk = m_p1_known; nkw = m_kw; nkr = m_kr;
      if (rst_n) begin
         nc = 16'd0; nkw = 0; nkr = 0; np1 = 16'd0; nk = 1'b1;
      end else if (flush) begin
         nc = 16'd0; nkw = 0; nkr = 0;
      end else begin
         if (m_kr < r_sched.size() && r_sched[m_kr] == int'(m_cnt)) begin
            np1 = m_mem[r_addr[m_kr]];
            nk  = m_mval[r_addr[m_kr]];
            nkr = m_kr + 1;
         end
         if (m_kw < w_sched.size() && w_sched[m_kw] == int'(m_cnt)) begin
            m_mem[w_addr[m_kw]]  = port_0;
            m_mval[w_addr[m_kw]] = 1'b1;
            nkw = m_kw + 1;
         end
         if (m_cnt != 16'hFFFF) nc = m_cnt + 16'd1;
      end
      @(posedge clk);
      #1;
      m_cnt = nc; m_p1 = np1; m_p1_known = nk; m_kw = nkw; m_kr = nkr;
      tcyc   = (rst_n || flush) ? 0 : tcyc + 1;
      port_0 = 16'(2 * tcyc) ^ pat;
      @(negedge clk);
      if (m_p1_known) begin
         n_vec++;
         if (port_1 !== m_p1) begin
            n_err++;
            $display("FAIL model_port_1 cnt=%0d tcyc=%0d: port_1=%h expected %h",
                     m_cnt, tcyc, port_1, m_p1);
         end
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic run_to(input logic [15:0] c);
      int guard;
      guard = 0;
      while (m_cnt != c && guard < 70000) begin
         step();
         guard++;
      end
      if (m_cnt != c) begin
         n_vec++; n_err++;
         $display("FAIL run_to: count %0d never reached %0d", m_cnt, c);
      end
   endtask

   task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: port_1=%h expected %h", name, got, exp);
      end
   endtask

   task automatic start(input logic [274:0] w, input logic [274:0] r, input logic [15:0] p);
      cfg = {r, w};
      pat = p;
      enumerate(w, 1'b0);
      enumerate(r, 1'b1);
      rst_n = 1'b1;
      flush = 1'b0;
      step();
      rst_n = 1'b0;
   endtask

   initial begin
      rst_n = 1'b1; flush = 1'b0; cfg = '0; port_0 = 16'd0; pat = 16'd0;
      tcyc = 0; m_cnt = 16'd0; m_p1 = 16'd0; m_p1_known = 1'b0; m_kw = 0; m_kr = 0;
      for (int i = 0; i < 512; i++) begin
         m_mem[i] = 16'd0; m_mval[i] = 1'b0;
      end

      // Linear copy
      start(pc(1, 1, 63, 0, 0, 1, 0, 0, 1, 0), pc(1, 1, 63, 0, 0, 1, 0, 64, 1, 0), 16'h0000);
      check("reset_port_1", port_1, 16'h0000);
      run_to(16'd65);  check("linear_k0",  port_1, 16'd0);
      run_to(16'd66);  check("linear_k1",  port_1, 16'd2);
      run_to(16'd128); check("linear_k63", port_1, 16'd126);
      run(10);         check("linear_hold", port_1, 16'd126);

      // 2-D transpose
      start(pc(1, 2, 3, 3, 0, 1, 4, 0, 1, 4), pc(1, 2, 3, 3, 0, 4, 1, 20, 1, 4), 16'h0000);
      run_to(16'd21); check("transpose_0", port_1, 16'd0);
      run_to(16'd22); check("transpose_1", port_1, 16'd8);
      run_to(16'd23); check("transpose_2", port_1, 16'd16);
      run_to(16'd24); check("transpose_3", port_1, 16'd24);
      run_to(16'd25); check("transpose_4", port_1, 16'd2);
      run_to(16'd36); check("transpose_last", port_1, 16'd30);
      run(5);         check("transpose_hold", port_1, 16'd30);

      // Idle: read disabled, then dim 0
      start(pc(1, 1, 63, 0, 0, 1, 0, 0, 1, 0), pc(0, 1, 63, 0, 0, 1, 0, 0, 1, 0), 16'h0000);
      run(1000); check("idle_enable0", port_1, 16'h0000);
      start(pc(1, 1, 63, 0, 0, 1, 0, 0, 1, 0), pc(1, 0, 63, 0, 0, 1, 0, 0, 1, 0), 16'h0000);
      run(200);  check("idle_dim0", port_1, 16'h0000);

      // Collision on address 5 at count 10
      start(pc(1, 1, 1, 0, 5, 0, 0, 2, 8, 0), pc(1, 1, 0, 0, 5, 0, 0, 10, 0, 0), 16'h5A00);
      run_to(16'd11); check("collision_old", port_1, 16'h5A04);
      run_to(16'd20); check("collision_hold", port_1, 16'h5A04);

      // Flush mid-run
      start(pc(1, 1, 63, 0, 0, 1, 0, 1, 1, 0), pc(1, 1, 63, 0, 0, 1, 0, 0, 1, 0), 16'h1000);
      run_to(16'd30);
      flush = 1'b1;
      step();
      pat = 16'h2000;
      step();
      flush = 1'b0;
      run_to(16'd1); check("flush_restart", port_1, 16'h1002);
      run_to(16'd6); check("flush_retained", port_1, 16'h100C);

      // Address wrap 510, 511, 0, 1
      start(pc(1, 1, 3, 0, 510, 1, 0, 0, 1, 0), pc(1, 1, 3, 0, 510, 1, 0, 10, 1, 0), 16'h3000);
      run_to(16'd11); check("wrap_510", port_1, 16'h3000);
      run_to(16'd13); check("wrap_0",   port_1, 16'h3004);
      run_to(16'd14); check("wrap_1",   port_1, 16'h3006);

      // Counter saturation: single write at 0xFFFF, three reads there
      start(pc(1, 1, 0, 0, 7, 0, 0, 65535, 0, 0), pc(1, 1, 2, 0, 7, 0, 0, 65535, 0, 0), 16'h0000);
      run_to(16'hFFFF);
      step();
      step(); check("sat_written", port_1, 16'hFFFE);
      step(); check("sat_once",    port_1, 16'hFFFE);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
